// File: rtl/reaction_counter_if.sv
// reaction_counter_if
//   Bundle between the reaction-timer master controller and the elapsed-time
//   counter.
//   clreset      : 1 = clear and hold the counter, 0 = let it run
//   count        : 5-digit packed BCD elapsed time, most significant digit first
//   count_binary : the same elapsed time in binary
//   tick         : one-cycle pulse on every increment
//   sat          : count is being held at 99999 (saturating build only)
//   The master modport is the controller side. The slave modport is the counter side.
interface reaction_counter_if;
  logic        clreset;
  logic [19:0] count;
  logic [19:0] count_binary;
  logic        tick;
  logic        sat;

  modport master (output clreset, input count, count_binary, tick, sat);
  modport slave  (input clreset, output count, count_binary, tick, sat);
endinterface

// File: rtl/reaction_counter.sv
// reaction_counter
//   Divides clk down to a TICK_HZ increment event. Each event advances a
//   5-digit packed-BCD count and a binary count that always agree.
//   Parameters : CLK_HZ, TICK_HZ (DIV = CLK_HZ/TICK_HZ, integer >= 2)
//   Ports      : clk - system clock (rising edge)
//                rst - asynchronous active-high reset
//                bus - reaction_counter_if.slave (clreset in; count,
//                      count_binary, tick, sat out)
//   Macro      : REACTION_CNT_SAT_EN - when defined, the count holds at 99999
//                and raises sat. When undefined, the count wraps to 0 and sat
//                is tied to 0.
module reaction_counter #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000
) (
  input  logic                clk,
  input  logic                rst,
  reaction_counter_if.slave   bus
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [19:0]      BIN_MAX  = 20'd99999;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [19:0]      count_q, count_d;
  logic [19:0]      bin_q, bin_d;
  logic             tick_q, tick_d;
  logic [19:0]      bcd_inc;
  logic             carry;

  // BCD +1 with the full ripple carry resolved in one cycle. 99999 wraps to 00000.
  always_comb begin
    bcd_inc = count_q;
    carry   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

`ifdef REACTION_CNT_SAT_EN
  logic sat_q, sat_d;
`endif

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    bin_d   = bin_q;
    tick_d  = 1'b0;
`ifdef REACTION_CNT_SAT_EN
    sat_d   = sat_q;
`endif
    if (bus.clreset) begin
      // A clear beats an increment on the same edge. It also restarts the tick phase.
      pre_d   = '0;
      count_d = '0;
      bin_d   = '0;
`ifdef REACTION_CNT_SAT_EN
      sat_d   = 1'b0;
`endif
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
`ifdef REACTION_CNT_SAT_EN
      if (bin_q != BIN_MAX) begin
        count_d = bcd_inc;
        bin_d   = bin_q + 20'd1;
        tick_d  = 1'b1;
        sat_d   = (bin_q == BIN_MAX - 20'd1);
      end
`else
      count_d = bcd_inc;
      bin_d   = (bin_q == BIN_MAX) ? 20'd0 : bin_q + 20'd1;
      tick_d  = 1'b1;
`endif
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      count_q <= '0;
      bin_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      bin_q   <= bin_d;
      tick_q  <= tick_d;
    end
  end

`ifdef REACTION_CNT_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end
  assign bus.sat = sat_q;
`else
  assign bus.sat = 1'b0;
`endif

  assign bus.count        = count_q;
  assign bus.count_binary = bin_q;
  assign bus.tick         = tick_q;

endmodule

// File: tb/tb_reaction_counter.sv
module tb_reaction_counter;
  localparam int DIV = 10;
`ifdef REACTION_CNT_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reaction_counter_if bus ();
  reaction_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;
  // Reference: elapsed value = base + (run edges since clear) / DIV
  int run  = 0;
  int base = 0;

  function automatic int raw_val();
    return base + run / DIV;
  endfunction

  function automatic int exp_val();
    int r = raw_val();
    if (SAT_BUILD) return (r > 99999) ? 99999 : r;
    return r % 100000;
  endfunction

  function automatic logic exp_tick();
    return (run > 0) && (run % DIV == 0) && (!SAT_BUILD || raw_val() <= 99999);
  endfunction

  function automatic logic exp_sat();
    return SAT_BUILD && (raw_val() >= 99999);
  endfunction

  function automatic logic [19:0] to_bcd(int v);
    logic [19:0] b = '0;
    int x = v;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  function automatic logic bcd_ok(logic [19:0] v);
    for (int i = 0; i < 5; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [41:0] expected();
    int v = exp_val();
    return {to_bcd(v), 20'(v), exp_tick(), exp_sat()};
  endfunction

  function automatic logic [41:0] observed();
    return {bus.count, bus.count_binary, bus.tick, bus.sat};
  endfunction

  // Advance one clock and the reference model; returns at the following negedge.
  task automatic cycle();
    @(posedge clk);
    if (rst || bus.clreset) begin
      run  = 0;
      base = 0;
    end else begin
      run++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.clreset = 1'b1;
    #1 rst = 1'b1;
    #1;
    nvec++;
    if (observed() !== 42'd0) begin
      nerr++;
      $display("FAIL reset_state: got %h want 0", observed());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      nvec++;
      if (observed() !== expected()) begin
        nerr++;
        $display("FAIL clreset_hold cyc%0d: got %h want %h", i, observed(), expected());
      end
    end
    bus.clreset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      nvec++;
      if (observed() !== expected()) begin
        nerr++;
        $display("FAIL first_run cyc%0d: got %h want %h", i, observed(), expected());
      end
    end
    nvec++;
    if ({bus.count, bus.count_binary, bus.tick} !== {20'h00001, 20'd1, 1'b1}) begin
      nerr++;
      $display("FAIL first_inc_cycle10: got count=%h bin=%0d tick=%b want 00001/1/1",
               bus.count, bus.count_binary, bus.tick);
    end
  endtask

  task automatic test_run_1234();
    int ticks = 0;
    int bad   = 0;
    bus.clreset = 1'b1;
    cycle();
    bus.clreset = 1'b0;
    for (int i = 0; i < 1234 * DIV; i++) begin
      cycle();
      ticks += int'(bus.tick);
      nvec++;
      if (observed() !== expected() || !bcd_ok(bus.count)) begin
        nerr++;
        if (bad++ < 5) $display("FAIL run1234 cyc%0d: got %h want %h", i, observed(), expected());
      end
    end
    nvec++;
    if ({bus.count, bus.count_binary} !== {20'h01234, 20'd1234} || ticks != 1234) begin
      nerr++;
      $display("FAIL run1234_end: got count=%h bin=%0d ticks=%0d want 01234/1234/1234",
               bus.count, bus.count_binary, ticks);
    end
  endtask

  task automatic test_carry();
    int bad = 0;
    bus.clreset = 1'b1;
    cycle();
    bus.clreset = 1'b0;
    for (int i = 0; i < 1000 * DIV; i++) begin
      cycle();
      nvec++;
      if (observed() !== expected() || !bcd_ok(bus.count)) begin
        nerr++;
        if (bad++ < 5) $display("FAIL carry cyc%0d: got %h want %h", i, observed(), expected());
      end
      if (i == 999 * DIV - 1) begin
        nvec++;
        if (bus.count !== 20'h00999) begin
          nerr++;
          $display("FAIL carry_pre: got %h want 00999", bus.count);
        end
      end
    end
    nvec++;
    if ({bus.count, bus.count_binary, bus.tick} !== {20'h01000, 20'd1000, 1'b1}) begin
      nerr++;
      $display("FAIL carry_1000: got count=%h bin=%0d tick=%b want 01000/1000/1",
               bus.count, bus.count_binary, bus.tick);
    end
  endtask

  task automatic test_clreset_pulse();
    int first = -1;
    bus.clreset = 1'b1;
    cycle();
    bus.clreset = 1'b0;
    for (int i = 0; i < 5 * DIV + 7; i++) cycle();
    bus.clreset = 1'b1;
    cycle();
    nvec++;
    if (observed() !== 42'd0) begin
      nerr++;
      $display("FAIL pulse_clear: got %h want 0", observed());
    end
    bus.clreset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (bus.tick === 1'b1 && first < 0) first = k;
      nvec++;
      if (observed() !== expected()) begin
        nerr++;
        $display("FAIL pulse_run cyc%0d: got %h want %h", k, observed(), expected());
      end
    end
    nvec++;
    if (first != DIV) begin
      nerr++;
      $display("FAIL pulse_latency: got %0d want %0d", first, DIV);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.clreset = ($urandom_range(0, 99) < 3);
      cycle();
      nvec++;
      if (observed() !== expected() || !bcd_ok(bus.count)) begin
        nerr++;
        if (bad++ < 5) $display("FAIL random cyc%0d: got %h want %h", i, observed(), expected());
      end
    end
    bus.clreset = 1'b0;
  endtask

  task automatic test_rollover();
    int ticks = 0;
    int bad   = 0;
    bus.clreset = 1'b1;
    cycle();
    bus.clreset = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    // Jump the count near the top instead of spending a million cycles to get there.
    force dut.count_q = 20'h99998;
    force dut.bin_q   = 20'd99998;
    base = 99998 - run / DIV;
    cycle();
    release dut.count_q;
    release dut.bin_q;
    for (int i = 0; i < 22 * DIV; i++) begin
      cycle();
      ticks += int'(bus.tick);
      nvec++;
      if (observed() !== expected() || !bcd_ok(bus.count)) begin
        nerr++;
        if (bad++ < 5) $display("FAIL rollover cyc%0d: got %h want %h", i, observed(), expected());
      end
    end
    nvec++;
    if (ticks != (SAT_BUILD ? 1 : 22)) begin
      nerr++;
      $display("FAIL rollover_ticks: got %0d want %0d", ticks, SAT_BUILD ? 1 : 22);
    end
  endtask

  task automatic test_async_rst();
    bus.clreset = 1'b1;
    cycle();
    bus.clreset = 1'b0;
    for (int i = 0; i < 42 * DIV; i++) cycle();
    nvec++;
    if (bus.count !== 20'h00042) begin
      nerr++;
      $display("FAIL pre_rst_count: got %h want 00042", bus.count);
    end
    #2 rst = 1'b1;
    run  = 0;
    base = 0;
    #1;
    nvec++;
    if (observed() !== 42'd0) begin
      nerr++;
      $display("FAIL async_rst: got %h want 0", observed());
    end
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      cycle();
      nvec++;
      if (observed() !== expected()) begin
        nerr++;
        $display("FAIL post_rst cyc%0d: got %h want %h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    bus.clreset = 1'b1;
    test_reset();
    test_run_1234();
    test_carry();
    test_clreset_pulse();
    test_random();
    test_rollover();
    test_async_rst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/reaction_counter.md
# reaction_counter

Millisecond timebase and elapsed-time counter feeding the reaction-timer master controller. Divides the system clock down to a 1 kHz tick and counts ticks simultaneously as a 5-digit packed-BCD value (displayed as the user's time and compared against the high score) and as a 20-bit binary value (compared against the saved random delay). The master controller holds it cleared or lets it run via `clreset`.

## Interface
- `CLK_HZ`, 50000000, system clock frequency in Hz
- `TICK_HZ`, 1000, count rate in Hz; `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `clreset`  in  1  synchronous clear/hold from the master controller; 1 = clear and hold, 0 = run
- `count`  out  20  packed BCD, digits [19:16]..[3:0], most significant first, range 00000–99999
- `count_binary`  out  20  same value in binary, range 0–99999
- `tick`  out  1  one-cycle pulse on each increment
- `sat`  out  1  high while the count is held at 99999 (macro build only)

## Operation
- Prescaler `pre`, width ceil(log2(DIV)), counts 0..DIV-1 and wraps to 0.
- `clreset`=1 has priority: next edge `pre`=0, `count`=0, `count_binary`=0, `tick`=0, `sat`=0. Held for as long as `clreset` stays high.
- `clreset`=0: `pre` increments. On the edge where `pre`==DIV-1, `pre` becomes 0 and the increment event fires:
  - BCD: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit. Ripple carry is resolved within one cycle.
  - Binary: `count_binary` is incremented by 1.
  - `tick` is 1 for exactly the following cycle.
- Invariant at every edge: `count_binary` equals the decimal value of `count`. No BCD digit ever exceeds 9.
- The outputs are registered directly. There is no combinational path from `clreset` to any output.
- Rollover at 99999 depends on `REACTION_CNT_SAT_EN` (see Configuration).

## Timing
- Reset values: `count`=0, `count_binary`=0, `tick`=0, `sat`=0, `pre`=0. Reset applies immediately on the asynchronous assertion of `rst` and overrides `clreset`.
- Latency: `clreset` falls before edge E0. The first increment is visible after edge E0+DIV-1, so `count`=1 is DIV cycles after the first run edge. Each later increment follows every DIV cycles.
- If `clreset` rises on the same edge an increment would occur, the clear wins: outputs go to 0 and `tick` stays 0.
- A `clreset` pulse of a single cycle fully clears `pre`, so the tick phase always restarts from 0.
- Reset asserted mid-count: everything returns to reset values and counting resumes once `rst` and `clreset` are both low.
- The master controller samples `count` and `count_binary` every cycle. The two outputs change on the same edge and are never skewed.

## Configuration
- `REACTION_CNT_SAT_EN` defined:
  - At 99999, further increment events leave both counts at 99999 and `tick` stays 0.
  - `sat` is 1 from the edge the count reaches 99999 until it is cleared.
- `REACTION_CNT_SAT_EN` not defined:
  - 99999 wraps to 00000 (BCD) and 0 (binary) on the next increment, with `tick` pulsing.
  - `sat` is constant 0.

## Test plan
All scenarios use `CLK_HZ`=10, `TICK_HZ`=1 (DIV=10).
- Reset release with `clreset`=1 for 5 cycles, then 0: counts stay 0 through cycle 9. At cycle 10, `count`=20'h00001, `count_binary`=1, and `tick` is high for one cycle.
- Run for 10×1234 cycles: `count`=20'h01234, `count_binary`=1234, and exactly 1234 `tick` pulses are observed.
- Carry chain from 20'h00999 → next tick gives 20'h01000 and `count_binary`=1000. Check every BCD digit ≤9 on all cycles.
- `clreset` pulsed for 1 cycle mid-count at `pre`=7: counts go to 0, and the next increment occurs 10 cycles after `clreset` falls.
- Run to 99999, then 20 more ticks:
  - With the macro: counts hold at 99999, `sat`=1, `tick`=0.
  - Without the macro: 00000/0 with `tick`, then 00001.
- Assert `rst` asynchronously between clock edges while `count`=20'h00042: outputs go to 0 immediately, without waiting for an edge.
